k_wptr_full_sync_t1: RTL
========================

// Module: k_wptr_full_sync_t1
// PURPOSE
// - Write-side flag stage of the async FIFO. Sits beside the dual Gray write-pointer counter.
// - Synchronises the read-domain Gray pointer into the write clock domain.
// - Compares it with the counter's Gray pointer and drives the counter's ready input (ready = ~full).
// - Also reports fill level, almost-full and write overflow to the write-side client.
// PARAMETERS
// - ADDR_W      3  FIFO address width; DEPTH = 2**ADDR_W; pointer width PTR_W = ADDR_W+1.
// - SYNC_STAGES 2  Flops in the rgray synchroniser chain, 2..4.
// - AF_THRESH   6  almost_full asserts when level >= AF_THRESH (1..DEPTH).
// PORTS
// - clk          in   1        Write-domain clock.
// - rst          in   1        Asynchronous, active-high reset.
// - wgray        in   PTR_W    Registered Gray write pointer from the dual Gray counter.
// - inc          in   1        Client write request, the same signal fed to the counter.
// - rgray_async  in   PTR_W    Gray read pointer from the read domain; not synchronous to clk.
// - full         out  1        FIFO full.
// - ready        out  1        ~full; drives the counter's ready input.
// - level        out  PTR_W    Registered occupancy, 0..DEPTH.
// - almost_full  out  1        Registered, level >= AF_THRESH.
// - overflow     out  1        Write attempted while full (see CONFIGURATION).
// BEHAVIOUR
// - Reset: while rst = 1, all synchroniser flops, level, almost_full and overflow are 0.
//   - With wgray = 0, full = 0 and ready = 1.
//   - Reset release mid-operation has no pending state; the block restarts from empty.
// - Synchroniser: rgray_async passes through SYNC_STAGES flops; the last stage is rgray_s.
//   - No logic sits between stages.
//   - No bit of rgray_async is used anywhere other than the first flop.
// - Full is combinational from wgray and rgray_s only, with no added latency:
//   - full = (wgray[PTR_W-1] != rgray_s[PTR_W-1]) && (wgray[PTR_W-2] != rgray_s[PTR_W-2])
//            && (wgray[PTR_W-3:0] == rgray_s[PTR_W-3:0]).
//   - It therefore reflects a new wgray in the same cycle the counter updates.
//   - A read-side pointer move reaches full after SYNC_STAGES clk edges.
// - Level: both pointers are Gray-to-binary converted inside this block; no shared converter.
//   - level <= (wbin - rbin_s) mod 2**PTR_W, registered one cycle after its inputs.
//   - The result is always in 0..DEPTH.
//   - Pointer wrap (bin 2**PTR_W-1 -> 0) needs no special case because the subtraction is modular.
// - almost_full <= (next level >= AF_THRESH), registered in the same edge as level.
//   - With AF_THRESH = DEPTH it is a registered copy of full.
// - Pessimism: full and level may lag a read by up to SYNC_STAGES+1 cycles.
//   - They never under-report occupancy.
// - Simultaneous events:
//   - Write and synchronised read in the same cycle: full is evaluated on current values only.
//   - inc while full: the counter holds because ready = 0; this block only flags overflow.
// - The block contains no FSM; its state is the sync chain, level, almost_full and overflow.
// CONFIGURATION
// - Macro WFULL_OVERFLOW_STICKY_EN:
//   - Defined: overflow is sticky. It sets on the first clk edge where inc && full and holds until rst.
//   - Undefined: overflow <= inc && full, a one-cycle registered pulse per rejected write.
//   - Both variants: overflow is 0 out of reset and never affects full, ready or level.
// TESTING (ADDR_W=3, SYNC_STAGES=2, AF_THRESH=6)
// - Reset: hold rst=1 with arbitrary rgray_async -> full=0, ready=1, level=0, almost_full=0, overflow=0.
// - Fill: rgray_async=4'b0000; step wgray through gray(0..8).
//   - full=1 exactly when wgray=4'b1100.
//   - level reads 8 one cycle later.
//   - almost_full rises one cycle after wgray=gray(6)=4'b0101.
// - Drain latency: from full, set rgray_async=4'b0001 (bin 1).
//   - full falls after exactly 2 clk edges; level=7 one cycle after that.
// - Wrap: wgray=gray(15)=4'b1000, rgray_async=gray(9)=4'b1101 -> level=6, full=0.
//   - Then wgray=gray(0)=4'b0000 -> level=7.
// - Overflow: full=1 and inc=1 for 3 cycles.
//   - Sticky: overflow=1 from the first edge until rst.
//   - Non-sticky: 3-cycle pulse, then 0.
// - Async reset mid-fill: assert rst between clk edges at level=5 -> outputs clear immediately, without a clock.

Source files
------------

// File: rtl/k_wptr_full_sync_t1_if.sv
// Write-side flag bundle between the write client, the dual Gray
// write-pointer counter and k_wptr_full_sync_t1.
//   wgray, inc, rgray_async : pointers and write request into the flag stage
//   full, ready             : full flag and its inverse for the counter
//   level, almost_full      : registered occupancy report
//   overflow                : rejected-write indication
interface k_wptr_full_sync_t1_if #(
    parameter int ADDR_W = 3
);
    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wgray;
    logic             inc;
    logic [PTR_W-1:0] rgray_async;
    logic             full;
    logic             ready;
    logic [PTR_W-1:0] level;
    logic             almost_full;
    logic             overflow;

    modport master (
        output wgray, inc, rgray_async,
        input  full, ready, level, almost_full, overflow
    );

    modport slave (
        input  wgray, inc, rgray_async,
        output full, ready, level, almost_full, overflow
    );
endinterface

// File: rtl/k_wptr_full_sync_t1.sv
// Write-side flag stage of the async FIFO: synchronises the read Gray
// pointer into clk, derives full/ready, level, almost_full and overflow.
// Ports: clk, rst (async, active high), bus (k_wptr_full_sync_t1_if.slave).
// Macro WFULL_OVERFLOW_STICKY_EN: overflow holds until rst once set;
// otherwise it is a one-cycle pulse per rejected write.
module k_wptr_full_sync_t1 #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input logic                  clk,
    input logic                  rst,
    k_wptr_full_sync_t1_if.slave bus
);
    localparam int PTR_W = ADDR_W + 1;

    function automatic logic [PTR_W-1:0] g2b(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        for (int i = 0; i < PTR_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] rgray_s;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] level_nxt;
    logic             full;
    logic             ovf_q;
    logic             af_q;
    logic [PTR_W-1:0] level_q;

    // Plain flop chain; only the first stage ever sees rgray_async.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rgray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rgray_s = sync_q[SYNC_STAGES-1];

    // Full when the pointers differ by exactly DEPTH: in Gray that is
    // the top two bits inverted and the rest equal.
    assign full =
        (bus.wgray[PTR_W-1] != rgray_s[PTR_W-1]) &&
        (bus.wgray[PTR_W-2] != rgray_s[PTR_W-2]) &&
        (bus.wgray[PTR_W-3:0] == rgray_s[PTR_W-3:0]);

    assign wbin      = g2b(bus.wgray);
    assign rbin_s    = g2b(rgray_s);
    // Modular difference handles pointer wrap without a special case.
    assign level_nxt = wbin - rbin_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            level_q <= level_nxt;
            af_q    <= (level_nxt >= PTR_W'(AF_THRESH));
`ifdef WFULL_OVERFLOW_STICKY_EN
            ovf_q   <= ovf_q | (bus.inc & full);
`else
            ovf_q   <= bus.inc & full;
`endif
        end
    end

    assign bus.full        = full;
    assign bus.ready       = ~full;
    assign bus.level       = level_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = ovf_q;
endmodule
